// File: rtl/alu_writeback.sv
// Execute/writeback stage: NZCV flag register, condition evaluation and a registered
// valid/ready writeback beat. Define ALU_WB_PERF_CNT_EN to add retired/skipped counters.
module alu_writeback #(
    parameter int N = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic         flush_i,
    input  logic [3:0]   cond_i,
    input  logic         set_flags_i,
    input  logic         logic_op_i,
    input  logic         write_rd_i,
    input  logic [3:0]   rd_i,
    input  logic [N-1:0] result_i,
    input  logic [3:0]   nzcv_i,
    output logic         wb_valid_o,
    input  logic         wb_ready_i,
    output logic         wb_we_o,
    output logic [3:0]   wb_rd_o,
    output logic [N-1:0] wb_data_o,
    output logic [3:0]   flags_o
`ifdef ALU_WB_PERF_CNT_EN
    ,
    output logic [31:0]  retired_cnt_o,
    output logic [31:0]  skipped_cnt_o
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } wb_state_e;

    wb_state_e      state_q;
    logic [3:0]     flags_q;
    logic           we_q;
    logic [3:0]     rd_q;
    logic [N-1:0]   data_q;
    logic           accept;
    logic           pass;
    logic           f_n, f_z, f_c, f_v;

    assign {f_n, f_z, f_c, f_v} = flags_q;

    // Conditions test the committed flags, so back-to-back instructions see each other's updates.
    always_comb begin
        // NOTE: pass gets a default before the case so no path leaves it unassigned (no latch).
        pass = 1'b0;
        case (cond_i)
            4'b0000: pass = f_z;
            4'b0001: pass = !f_z;
            4'b0010: pass = f_c;
            4'b0011: pass = !f_c;
            4'b0100: pass = f_n;
            4'b0101: pass = !f_n;
            4'b0110: pass = f_v;
            4'b0111: pass = !f_v;
            4'b1000: pass = f_c && !f_z;
            4'b1001: pass = !f_c || f_z;
            4'b1010: pass = (f_n == f_v);
            4'b1011: pass = (f_n != f_v);
            4'b1100: pass = !f_z && (f_n == f_v);
            4'b1101: pass = f_z || (f_n != f_v);
            4'b1110: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

    assign ready_o = (state_q == EMPTY) || wb_ready_i;
    assign accept  = valid_i && ready_o && !flush_i;

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            state_q <= EMPTY;
            flags_q <= 4'b0000;
            we_q    <= 1'b0;
            rd_q    <= 4'd0;
            data_q  <= '0;
        end else begin
            if (flush_i) begin
                state_q <= EMPTY;
            end else if (accept && pass && write_rd_i) begin
                state_q <= FULL;
                we_q    <= 1'b1;
                rd_q    <= rd_i;
                data_q  <= result_i;
            end else if (state_q == FULL && wb_ready_i) begin
                state_q <= EMPTY;
            end

            // Logical ops leave C and V untouched.
            if (accept && pass && set_flags_i) begin
                if (logic_op_i)
                    flags_q <= {nzcv_i[3], nzcv_i[2], flags_q[1], flags_q[0]};
                else
                    flags_q <= nzcv_i;
            end
        end
    end

    assign wb_valid_o = (state_q == FULL);
    assign wb_we_o    = we_q;
    assign wb_rd_o    = rd_q;
    assign wb_data_o  = data_q;
    assign flags_o    = flags_q;

`ifdef ALU_WB_PERF_CNT_EN
    logic [31:0] retired_cnt_q;
    logic [31:0] skipped_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            retired_cnt_q <= 32'd0;
            skipped_cnt_q <= 32'd0;
        end else if (accept) begin
            if (pass)
                retired_cnt_q <= retired_cnt_q + 32'd1;
            else
                skipped_cnt_q <= skipped_cnt_q + 32'd1;
        end
    end

    assign retired_cnt_o = retired_cnt_q;
    assign skipped_cnt_o = skipped_cnt_q;
`endif

endmodule
